// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire.
// Optional macro ROB_WB_BYPASS_EN forwards a head writeback to the commit port in the same cycle.

package riscv_pkg;
  localparam int unsigned XLEN = 32;
  typedef logic [XLEN-1:0] data_t;
endpackage

package tortoise_pkg;
  localparam int unsigned CAUSE_W = 6;

  typedef struct packed {
    logic                   valid;
    logic [CAUSE_W-1:0]     cause;
    riscv_pkg::data_t       tval;
  } exception_t;

  typedef struct packed {
    logic                   valid;
    riscv_pkg::data_t       value;
  } result_t;

  typedef struct packed {
    riscv_pkg::data_t       pc;
    logic [7:0]             op;
    logic [4:0]             rd;
    result_t                result;
    exception_t             ex;
  } scoreboard_entry_t;
endpackage

module reorder_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NR_WB = 2,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic                                         issue_valid_i,
  output logic                                         issue_ready_o,
  input  tortoise_pkg::scoreboard_entry_t              issue_instr_i,
  output logic [IDX_W-1:0]                             issue_idx_o,
  input  logic [NR_WB-1:0]                             wb_valid_i,
  input  logic [NR_WB-1:0][IDX_W-1:0]                  wb_idx_i,
  input  riscv_pkg::data_t [NR_WB-1:0]                 wb_data_i,
  input  tortoise_pkg::exception_t [NR_WB-1:0]         wb_ex_i,
  output logic                                         commit_valid_o,
  output tortoise_pkg::scoreboard_entry_t              commit_instr_o,
  input  logic                                         commit_ack_i,
  output logic [CNT_W-1:0]                             count_o
);

  import tortoise_pkg::*;

  scoreboard_entry_t mem_q [DEPTH];
  scoreboard_entry_t mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  scoreboard_entry_t head_view;
  logic              alloc, retire;

  assign issue_ready_o  = (count_q != CNT_W'(DEPTH));
  assign issue_idx_o    = tail_q;
  assign count_o        = count_q;
  assign commit_instr_o = head_view;
  assign commit_valid_o = busy_q[head_q] && (head_view.result.valid || head_view.ex.valid);

  assign alloc  = issue_valid_i && issue_ready_o && !flush_i;
  assign retire = commit_ack_i && commit_valid_o && !flush_i;

  // Head entry as seen by the commit stage
  always_comb begin
    head_view = mem_q[head_q];
`ifdef ROB_WB_BYPASS_EN
    for (int p = 0; p < NR_WB; p++) begin
      if (wb_valid_i[p] && busy_q[head_q] && (wb_idx_i[p] == head_q)) begin
        head_view.result.valid = 1'b1;
        head_view.result.value = wb_data_i[p];
        head_view.ex           = wb_ex_i[p];
      end
    end
`endif
  end

  // Next-state: flush overrides allocate, writeback and retire
  always_comb begin
    mem_d   = mem_q;
    busy_d  = busy_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush_i) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc) begin
        mem_d[tail_q]              = issue_instr_i;
        mem_d[tail_q].result.valid = 1'b0;
        mem_d[tail_q].ex.valid     = 1'b0;
        busy_d[tail_q]             = 1'b1;
        tail_d                     = tail_q + IDX_W'(1);
      end

      // Later ports overwrite earlier ones on a tag collision
      for (int p = 0; p < NR_WB; p++) begin
        if (wb_valid_i[p] && busy_q[wb_idx_i[p]]) begin
          mem_d[wb_idx_i[p]].result.valid = 1'b1;
          mem_d[wb_idx_i[p]].result.value = wb_data_i[p];
          mem_d[wb_idx_i[p]].ex           = wb_ex_i[p];
        end
      end

      if (retire) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + IDX_W'(1);
      end

      count_d = count_q + CNT_W'(alloc) - CNT_W'(retire);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      busy_q  <= busy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; expectations adapt to ROB_WB_BYPASS_EN.

module tb_reorder_buffer;
  import tortoise_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NR_WB = 2;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;
`ifdef ROB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                               clk = 1'b0;
  logic                               rst_n;
  logic                               flush;
  logic                               issue_valid;
  logic                               issue_ready;
  scoreboard_entry_t                  issue_instr;
  logic [IDX_W-1:0]                   issue_idx;
  logic [NR_WB-1:0]                   wb_valid;
  logic [NR_WB-1:0][IDX_W-1:0]        wb_idx;
  riscv_pkg::data_t [NR_WB-1:0]       wb_data;
  exception_t [NR_WB-1:0]             wb_ex;
  logic                               commit_valid;
  scoreboard_entry_t                  commit_instr;
  logic                               commit_ack;
  logic [CNT_W-1:0]                   count;

  int n_vec = 0;
  int n_err = 0;

  reorder_buffer #(.DEPTH(DEPTH), .NR_WB(NR_WB)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .issue_instr_i  (issue_instr),
    .issue_idx_o    (issue_idx),
    .wb_valid_i     (wb_valid),
    .wb_idx_i       (wb_idx),
    .wb_data_i      (wb_data),
    .wb_ex_i        (wb_ex),
    .commit_valid_o (commit_valid),
    .commit_instr_o (commit_instr),
    .commit_ack_i   (commit_ack),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result/ex valid bits set so the bench sees them cleared on allocation
  function automatic scoreboard_entry_t mk(input logic [31:0] pc);
    scoreboard_entry_t e;
    e              = '0;
    e.pc           = pc;
    e.op           = pc[7:0];
    e.rd           = pc[4:0];
    e.result.valid = 1'b1;
    e.result.value = 32'hDEAD_BEEF;
    e.ex.valid     = 1'b1;
    return e;
  endfunction

  task automatic wb_off();
    wb_valid = '0;
    wb_idx   = '0;
    wb_data  = '0;
    wb_ex    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_instr = '0; commit_ack = 1'b0;
    wb_off();
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(issue_ready), 64'd1);
    check("rst_cvalid", 64'(commit_valid), 64'd0);
    check("rst_idx", 64'(issue_idx), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill all eight slots back-to-back
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1;
      issue_instr = mk(32'(i));
      #1;
      check($sformatf("fill_idx%0d", i), 64'(issue_idx), 64'(i));
      tick();
    end
    issue_valid = 1'b0;
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(issue_ready), 64'd0);
    check("full_cvalid", 64'(commit_valid), 64'd0);
    check("full_head_pc", 64'(commit_instr.pc), 64'd0);

    // Head writeback: same-cycle visibility only with the bypass
    wb_valid = 2'b01; wb_idx[0] = 3'd0; wb_data[0] = 32'hA0;
    #1;
    check("wb_head_same_cycle", 64'(commit_valid), 64'(BYP));
    tick();
    wb_off();
    check("wb_head_next_cycle", 64'(commit_valid), 64'd1);
    check("wb_head_value", 64'(commit_instr.result.value), 64'hA0);

    // Full + complete head: retire accepted, issue rejected
    issue_valid = 1'b1; issue_instr = mk(32'h99); commit_ack = 1'b1;
    #1;
    check("full_ack_ready", 64'(issue_ready), 64'd0);
    tick();
    issue_valid = 1'b0; commit_ack = 1'b0;
    check("full_ack_count", 64'(count), 64'd7);
    check("full_ack_ready_after", 64'(issue_ready), 64'd1);
    check("full_ack_head_pc", 64'(commit_instr.pc), 64'd1);
    check("full_ack_tail", 64'(issue_idx), 64'd0);

    // Retire two more to leave five entries
    wb_valid = 2'b11; wb_idx[0] = 3'd1; wb_data[0] = 32'h1; wb_idx[1] = 3'd2; wb_data[1] = 32'h2;
    tick();
    wb_off();
    commit_ack = 1'b1;
    tick(); tick();
    commit_ack = 1'b0;
    check("five_count", 64'(count), 64'd5);
    check("five_head_pc", 64'(commit_instr.pc), 64'd3);

    // Flush wins over issue, ack and writeback
    flush = 1'b1; issue_valid = 1'b1; issue_instr = mk(32'h77); commit_ack = 1'b1;
    wb_valid = 2'b01; wb_idx[0] = 3'd3; wb_data[0] = 32'h33;
    tick();
    flush = 1'b0; issue_valid = 1'b0; commit_ack = 1'b0;
    wb_off();
    check("flush_count", 64'(count), 64'd0);
    check("flush_tail", 64'(issue_idx), 64'd0);
    check("flush_cvalid", 64'(commit_valid), 64'd0);
    check("flush_ready", 64'(issue_ready), 64'd1);

    // Fill tags 0..3 and complete them out of order
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1;
      issue_instr = mk(32'h100 + 32'(i));
      #1;
      check($sformatf("ooo_idx%0d", i), 64'(issue_idx), 64'(i));
      tick();
    end
    issue_valid = 1'b0;
    check("ooo_head_pc", 64'(commit_instr.pc), 64'h100);
    wb_valid = 2'b10; wb_idx[1] = 3'd2; wb_data[1] = 32'h2222;
    tick();
    wb_off();
    check("ooo_tag2_blocked", 64'(commit_valid), 64'd0);
    wb_valid = 2'b01; wb_idx[0] = 3'd0; wb_data[0] = 32'h1000;
    #1;
    check("ooo_tag0_same_cycle", 64'(commit_valid), 64'(BYP));
    tick();
    wb_off();
    check("ooo_tag0_valid", 64'(commit_valid), 64'd1);
    check("ooo_tag0_value", 64'(commit_instr.result.value), 64'h1000);
    commit_ack = 1'b1;
    tick();
    check("ooo_retire0_count", 64'(count), 64'd3);
    check("ooo_tag1_blocks", 64'(commit_valid), 64'd0);
    check("ooo_head1_pc", 64'(commit_instr.pc), 64'h101);
    tick();
    check("ooo_ack_ignored", 64'(count), 64'd3);
    commit_ack = 1'b0;

    // Both ports hit tag 3: port 1 wins
    wb_valid = 2'b11; wb_idx[0] = 3'd3; wb_data[0] = 32'h11; wb_idx[1] = 3'd3; wb_data[1] = 32'h22;
    tick();
    wb_off();
    wb_valid = 2'b01; wb_idx[0] = 3'd1; wb_data[0] = 32'h1111;
    tick();
    wb_off();
    check("ooo_tag1_valid", 64'(commit_valid), 64'd1);
    check("ooo_tag1_value", 64'(commit_instr.result.value), 64'h1111);
    commit_ack = 1'b1;
    tick();
    check("ooo_tag2_pc", 64'(commit_instr.pc), 64'h102);
    check("ooo_tag2_value", 64'(commit_instr.result.value), 64'h2222);
    tick();
    check("ooo_tag3_valid", 64'(commit_valid), 64'd1);
    check("dual_wb_value", 64'(commit_instr.result.value), 64'h22);
    tick();
    commit_ack = 1'b0;
    check("ooo_drained", 64'(count), 64'd0);
    check("ooo_drained_cvalid", 64'(commit_valid), 64'd0);

    // Twelve issue/retire pairs, tail and head wrap 7->0
    for (int k = 0; k < 12; k++) begin
      logic [IDX_W-1:0] tag;
      int               port;
      tag  = IDX_W'(4 + k);
      port = k % 2;
      issue_valid = 1'b1;
      issue_instr = mk(32'h200 + 32'(k));
      #1;
      check($sformatf("wrap_idx%0d", k), 64'(issue_idx), 64'(tag));
      tick();
      issue_valid = 1'b0;
      check($sformatf("wrap_pending%0d", k), 64'(commit_valid), 64'd0);
      wb_valid[port] = 1'b1;
      wb_idx[port]   = tag;
      wb_data[port]  = 32'h300 + 32'(k);
      if (k == 5) begin
        wb_ex[port].valid = 1'b1;
        wb_ex[port].cause = 6'd2;
      end
      tick();
      wb_off();
      check($sformatf("wrap_cvalid%0d", k), 64'(commit_valid), 64'd1);
      check($sformatf("wrap_value%0d", k), 64'(commit_instr.result.value), 64'h300 + 64'(k));
      check($sformatf("wrap_exv%0d", k), 64'(commit_instr.ex.valid), 64'(k == 5));
      commit_ack = 1'b1;
      tick();
      commit_ack = 1'b0;
      check($sformatf("wrap_count%0d", k), 64'(count), 64'd0);
    end
    check("wrap_final_tail", 64'(issue_idx), 64'd0);

    // Writeback to an empty head is ignored
    wb_valid = 2'b01; wb_idx[0] = 3'd0; wb_data[0] = 32'h55;
    #1;
    check("empty_wb_same", 64'(commit_valid), 64'd0);
    tick();
    wb_off();
    check("empty_wb_next", 64'(commit_valid), 64'd0);
    check("empty_wb_count", 64'(count), 64'd0);

    // Asynchronous reset between clock edges
    for (int i = 0; i < 2; i++) begin
      issue_valid = 1'b1;
      issue_instr = mk(32'h400 + 32'(i));
      tick();
    end
    issue_valid = 1'b0;
    check("pre_arst_count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_idx", 64'(issue_idx), 64'd0);
    check("arst_ready", 64'(issue_ready), 64'd1);
    check("arst_cvalid", 64'(commit_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
